div_recon_u27_u21: RTL and testbench
====================================

# div_recon_u27_u21

Iterative reconstructor for the div_u27_u21 divider results. It takes quotient, denominator and remainder, and rebuilds the numerator as numer = quotient × denom + remain using a radix-2 shift-add multiplier. It sits downstream of the divider in self-checking demos and in on-chip BIST: a result is correct when the rebuilt numerator equals the original input. The interface is a valid/ready handshake on both sides, with one operation in flight at a time.

## Interface
- WIDTHN, 27, quotient/numerator width
- WIDTHD, 21, denominator/remainder width; also the multiplier iteration count
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand set valid
- in_ready  output  1  block idle, can accept
- quotient  input  WIDTHN  unsigned quotient
- denom  input  WIDTHD  unsigned denominator
- remain  input  WIDTHD  unsigned remainder
- out_valid  output  1  result valid, held until taken
- out_ready  input  1  consumer accepts result
- numer  output  WIDTHN  low WIDTHN bits of quotient × denom + remain
- overflow  output  1  full sum ≥ 2^WIDTHN
- remain_err  output  1  remain ≥ denom, or denom == 0

## Operation
- States: IDLE, MUL, ADD, DONE. Reset enters IDLE.
- in_ready = (state == IDLE).
- IDLE, on in_valid && in_ready:
  - Latch the operands.
  - Clear the accumulator (WIDTHN+WIDTHD+1 bits) and the bit counter.
  - Go to MUL.
- MUL: one denom bit per cycle, LSB first.
  - If the bit is 1, add the shifted quotient to the accumulator.
  - Shift the multiplicand left by 1 and increment the counter.
  - After WIDTHD iterations, go to ADD. There is no early exit; latency is fixed.
- ADD:
  - Add the zero-extended remain to the accumulator.
  - Register numer = acc[WIDTHN-1:0].
  - Register overflow = |acc[top:WIDTHN].
  - Register remain_err = (remain ≥ denom) || (denom == 0).
  - Go to DONE.
- DONE: out_valid = 1 and outputs are held stable.
  - On out_ready, go to IDLE.
  - A new operand set is accepted no earlier than the cycle after leaving DONE.
- denom == 0: product is 0, numer = remain, remain_err = 1.
- Arithmetic is unsigned only. The signed variant is out of scope.
- Reset in any state returns to IDLE and discards the operation in flight.
- Reset values:
  - out_valid = 0, numer = 0, overflow = 0, remain_err = 0.
  - in_ready = 1 once the block is in IDLE after reset.

## Timing
- Accept edge T (in_valid && in_ready sampled high).
- MUL occupies edges T+1 … T+WIDTHD.
- ADD result is registered at edge T+WIDTHD+1.
- out_valid is high from that edge. Latency is WIDTHD+1 = 22 clocks.
- Completion edge C (out_valid && out_ready): the block is in IDLE after C and in_ready is high in the following cycle.
- Peak throughput: one operation per WIDTHD+3 = 24 clocks.
- in_valid asserted outside IDLE is ignored. The upstream source must hold its data until in_ready is high.
- out_ready asserted while out_valid is low has no effect.

## Configuration
- DIV_RECON_CHECK_EN defined:
  - Adds input numer_exp (WIDTHN bits), latched at accept.
  - Adds output match = (numer == numer_exp) && !overflow && !remain_err, valid with out_valid.
  - Adds output fail_sticky, set on any completed operation with match == 0. It is cleared only by reset.
- DIV_RECON_CHECK_EN undefined: those ports and their logic are absent. Core behaviour is identical.

## Structure
- The shared package div_u27_u21_pkg holds:
  - the WIDTHN/WIDTHD default constants;
  - the accumulator width constant WIDTHN+WIDTHD+1;
  - the state typedef (IDLE, MUL, ADD, DONE).
- One sub-module, div_recon_datapath, contains:
  - the accumulator;
  - the multiplicand shift register;
  - the iteration counter;
  - the remain add and the flag logic.
- The top level holds the FSM and the handshake.

## Test plan
- quotient=2, denom=3, remain=2 → numer=8, overflow=0, remain_err=0, out_valid exactly 22 clocks after accept.
- quotient=3, denom=4, remain=3 → numer=15. Issue a second set (16/3: q=5, d=3, r=1) back-to-back → numer=16, accepted 24 clocks after the first accept.
- quotient=2^27−1, denom=3, remain=0 → overflow=1, numer=134217725. Then quotient=2^27−1, denom=1, remain=0 → numer=134217727, overflow=0.
- denom=0, remain=7 → numer=7, remain_err=1. Then denom=5, remain=5 → remain_err=1.
- Hold out_ready low for 10 cycles in DONE → numer and flags stable, in_ready=0. Pulse in_valid during the stall → ignored.
- Assert reset at MUL iteration 10 → all outputs 0 and in_ready=1 after release. A new op 10/5 (q=2, d=5, r=0) → numer=10. With DIV_RECON_CHECK_EN: numer_exp=11 → match=0, fail_sticky=1, held across later passing ops.

Source files
------------

// File: rtl/div_u27_u21_pkg.sv
// ----------------------------------------------------------------------------
// div_u27_u21_pkg
// Shared constants and types for the u27/u21 divider family and its result
// reconstructor.
//   WIDTHN  quotient / numerator width
//   WIDTHD  denominator / remainder width (also the multiply iteration count)
//   ACC_W   reconstruction accumulator width (one spare bit above the sum)
//   CNT_W   width of the multiply iteration counter
//   state_t reconstructor FSM states
// Optional feature macro used by importers: DIV_RECON_CHECK_EN.
// ----------------------------------------------------------------------------
package div_u27_u21_pkg;

  localparam int WIDTHN = 27;
  localparam int WIDTHD = 21;
  localparam int ACC_W  = WIDTHN + WIDTHD + 1;
  localparam int CNT_W  = $clog2(WIDTHD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_recon_u27_u21_if.sv
// ----------------------------------------------------------------------------
// div_recon_u27_u21_if
// Valid/ready operand and result bundle of the u27/u21 reconstructor.
//   master : producer of operands / consumer of results (upstream + downstream)
//   slave  : the reconstructor itself
// Operand side : in_valid, in_ready, quotient, denom, remain
// Result side  : out_valid, out_ready, numer, overflow, remain_err
// With DIV_RECON_CHECK_EN defined: numer_exp (operand), match, fail_sticky
// (results) are added.
// ----------------------------------------------------------------------------
interface div_recon_u27_u21_if;
  import div_u27_u21_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTHN-1:0] quotient;
  logic [WIDTHD-1:0] denom;
  logic [WIDTHD-1:0] remain;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTHN-1:0] numer;
  logic              overflow;
  logic              remain_err;
`ifdef DIV_RECON_CHECK_EN
  logic [WIDTHN-1:0] numer_exp;
  logic              match;
  logic              fail_sticky;

  modport master (
    output in_valid, quotient, denom, remain, numer_exp, out_ready,
    input  in_ready, out_valid, numer, overflow, remain_err, match, fail_sticky
  );
  modport slave (
    input  in_valid, quotient, denom, remain, numer_exp, out_ready,
    output in_ready, out_valid, numer, overflow, remain_err, match, fail_sticky
  );
`else
  modport master (
    output in_valid, quotient, denom, remain, out_ready,
    input  in_ready, out_valid, numer, overflow, remain_err
  );
  modport slave (
    input  in_valid, quotient, denom, remain, out_ready,
    output in_ready, out_valid, numer, overflow, remain_err
  );
`endif

endinterface

// File: rtl/div_recon_datapath.sv
// ----------------------------------------------------------------------------
// div_recon_datapath
// Radix-2 shift-add reconstruction datapath: acc = quotient * denom, then
// numer = acc + remain with overflow / remainder-consistency flags.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start        load operands, clear accumulator and counter
//   mul_en       perform one multiply iteration (one denom bit, LSB first)
//   add_en       add remain and register numer / flags
//   quotient, denom, remain   operands
//   mul_last     current multiply iteration is the final one
//   numer, overflow, remain_err  registered results
// With DIV_RECON_CHECK_EN defined: numer_exp input, match and fail_sticky
// outputs (fail_sticky cleared only by reset).
// ----------------------------------------------------------------------------
module div_recon_datapath
  import div_u27_u21_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mul_en,
  input  logic              add_en,
  input  logic [WIDTHN-1:0] quotient,
  input  logic [WIDTHD-1:0] denom,
  input  logic [WIDTHD-1:0] remain,
`ifdef DIV_RECON_CHECK_EN
  input  logic [WIDTHN-1:0] numer_exp,
  output logic              match,
  output logic              fail_sticky,
`endif
  output logic              mul_last,
  output logic [WIDTHN-1:0] numer,
  output logic              overflow,
  output logic              remain_err
);

  logic [WIDTHD-1:0] denom_q;    // kept whole for the remain_err compare
  logic [WIDTHD-1:0] remain_q;
  logic [WIDTHD-1:0] denom_sh;   // shifted right, bit 0 is the current bit
  logic [ACC_W-1:0]  mcand;      // quotient shifted left once per iteration
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;

  logic [ACC_W-1:0]  sum;
  logic              ovf_next;
  logic              rerr_next;

  // NOTE: operand registers carry no reset; they are always loaded on accept
  // before anything reads them, so a reset term would only add fan-out.
  always_ff @(posedge clk) begin
    if (start) begin
      denom_q  <= denom;
      remain_q <= remain;
    end
  end

  // NOTE: sequential state always uses non-blocking assignment so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      denom_sh <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else if (start) begin
      denom_sh <= denom;
      mcand    <= ACC_W'(quotient);
      acc      <= '0;
      cnt      <= '0;
    end else if (mul_en) begin
      if (denom_sh[0]) acc <= acc + mcand;
      denom_sh <= denom_sh >> 1;
      mcand    <= mcand << 1;
      cnt      <= cnt + 1'b1;
    end
  end

  assign mul_last = (cnt == CNT_W'(WIDTHD - 1));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sum       = '0;
    ovf_next  = 1'b0;
    rerr_next = 1'b0;
    sum       = acc + ACC_W'(remain_q);
    ovf_next  = |sum[ACC_W-1:WIDTHN];
    rerr_next = (remain_q >= denom_q) || (denom_q == '0);
  end

  // Results only change in ADD, so they stay stable through DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      numer      <= '0;
      overflow   <= 1'b0;
      remain_err <= 1'b0;
    end else if (add_en) begin
      numer      <= sum[WIDTHN-1:0];
      overflow   <= ovf_next;
      remain_err <= rerr_next;
    end
  end

`ifdef DIV_RECON_CHECK_EN
  logic [WIDTHN-1:0] numer_exp_q;
  logic              match_next;

  always_ff @(posedge clk) begin
    if (start) numer_exp_q <= numer_exp;
  end

  assign match_next = (sum[WIDTHN-1:0] == numer_exp_q) && !ovf_next && !rerr_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match       <= 1'b0;
      fail_sticky <= 1'b0;
    end else if (add_en) begin
      match       <= match_next;
      fail_sticky <= fail_sticky | !match_next;
    end
  end
`endif

endmodule

// File: rtl/div_recon_u27_u21.sv
// ----------------------------------------------------------------------------
// div_recon_u27_u21
// Rebuilds numer = quotient * denom + remain from div_u27_u21 results, one
// operation in flight, fixed latency of WIDTHD+1 clocks from accept to
// out_valid.
// Ports:
//   clk    clock
//   reset  asynchronous, active-high; aborts any operation in flight
//   bus    div_recon_u27_u21_if.slave (operand and result handshakes)
// Optional: DIV_RECON_CHECK_EN adds numer_exp / match / fail_sticky.
// ----------------------------------------------------------------------------
module div_recon_u27_u21
  import div_u27_u21_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  div_recon_u27_u21_if.slave    bus
);

  state_t state;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   start;
  logic   mul_en;
  logic   add_en;
  logic   mul_last;

  assign start  = (state == IDLE) && bus.in_valid;
  assign mul_en = (state == MUL);
  assign add_en = (state == ADD);

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  // in_ready / out_valid are registered alongside the state so they track it
  // exactly without decoding glitches on the handshake wires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state      <= MUL;
          in_ready_q <= 1'b0;
        end
        MUL: if (mul_last) state <= ADD;
        ADD: begin
          state       <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  div_recon_datapath u_datapath (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mul_en     (mul_en),
    .add_en     (add_en),
    .quotient   (bus.quotient),
    .denom      (bus.denom),
    .remain     (bus.remain),
`ifdef DIV_RECON_CHECK_EN
    .numer_exp  (bus.numer_exp),
    .match      (bus.match),
    .fail_sticky(bus.fail_sticky),
`endif
    .mul_last   (mul_last),
    .numer      (bus.numer),
    .overflow   (bus.overflow),
    .remain_err (bus.remain_err)
  );

endmodule

// File: tb/tb_div_recon_u27_u21.sv
// ----------------------------------------------------------------------------
// tb_div_recon_u27_u21
// Self-checking bench for div_recon_u27_u21: directed latency / throughput,
// a vector table, random operands against an arithmetic model, output stall,
// and reset in the middle of a multiply. Works with or without
// DIV_RECON_CHECK_EN.
// ----------------------------------------------------------------------------
module tb_div_recon_u27_u21;
  import div_u27_u21_pkg::*;

  typedef struct {
    logic [WIDTHN-1:0] numer;
    logic              ovf;
    logic              rerr;
    logic              match;
  } exp_t;

  typedef struct {
    logic [WIDTHN-1:0] q;
    logic [WIDTHD-1:0] d;
    logic [WIDTHD-1:0] r;
    logic [WIDTHN-1:0] numer;
    logic              ovf;
    logic              rerr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   accept_cyc = 0;
  int   valid_cyc = 0;
  logic sticky_exp = 1'b0;
  exp_t sb[$];
  vec_t vecs[$];

  div_recon_u27_u21_if bus_if ();

  div_recon_u27_u21 dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTHN-1:0] q, input logic [WIDTHD-1:0] d,
                                 input logic [WIDTHD-1:0] r);
    exp_t e;
    logic [63:0] s;
    s       = 64'(q) * 64'(d) + 64'(r);
    e.numer = s[WIDTHN-1:0];
    e.ovf   = (s >> WIDTHN) != 64'd0;
    e.rerr  = (r >= d) || (d == '0);
    e.match = !e.ovf && !e.rerr;
    return e;
  endfunction

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic send(input logic [WIDTHN-1:0] q, input logic [WIDTHD-1:0] d,
                      input logic [WIDTHD-1:0] r, input logic [WIDTHN-1:0] ne,
                      input exp_t e);
    int n = 0;
    while (!bus_if.in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_send", bus_if.in_ready, 1);
    if (bus_if.in_ready !== 1'b1) return;
    bus_if.in_valid = 1'b1;
    bus_if.quotient = q;
    bus_if.denom    = d;
    bus_if.remain   = r;
`ifdef DIV_RECON_CHECK_EN
    bus_if.numer_exp = ne;
`else
    if (ne != '0) begin end
`endif
    @(posedge clk); #1;
    accept_cyc      = cyc;
    bus_if.in_valid = 1'b0;
    sb.push_back(e);
  endtask

  // Waits (bounded) for out_valid with out_ready high, compares, completes.
  task automatic recv(input string tag);
    int   n = 0;
    exp_t e;
    bus_if.out_ready = 1'b1;
    while (!bus_if.out_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    valid_cyc = cyc;
    check({tag, "_out_valid"}, bus_if.out_valid, 1);
    if (bus_if.out_valid !== 1'b1 || sb.size() == 0) begin
      bus_if.out_ready = 1'b0;
      return;
    end
    e = sb.pop_front();
    check({tag, "_numer"}, bus_if.numer, e.numer);
    check({tag, "_overflow"}, bus_if.overflow, e.ovf);
    check({tag, "_remain_err"}, bus_if.remain_err, e.rerr);
`ifdef DIV_RECON_CHECK_EN
    sticky_exp = sticky_exp | !e.match;
    check({tag, "_match"}, bus_if.match, e.match);
    check({tag, "_fail_sticky"}, bus_if.fail_sticky, sticky_exp);
`endif
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    check({tag, "_out_valid_clear"}, bus_if.out_valid, 0);
  endtask

  initial begin
    exp_t e;
    int   acc0;
    logic [WIDTHN-1:0] q;
    logic [WIDTHD-1:0] d, r;

    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.quotient  = '0;
    bus_if.denom     = '0;
    bus_if.remain    = '0;
`ifdef DIV_RECON_CHECK_EN
    bus_if.numer_exp = '0;
`endif

    vecs.push_back('{27'd3, 21'd4, 21'd3, 27'd15, 1'b0, 1'b0});
    vecs.push_back('{27'd134217727, 21'd3, 21'd0, 27'd134217725, 1'b1, 1'b0});
    vecs.push_back('{27'd134217727, 21'd1, 21'd0, 27'd134217727, 1'b0, 1'b0});
    vecs.push_back('{27'd9, 21'd0, 21'd7, 27'd7, 1'b0, 1'b1});
    vecs.push_back('{27'd4, 21'd5, 21'd5, 27'd25, 1'b0, 1'b1});
    vecs.push_back('{27'd2, 21'd5, 21'd0, 27'd10, 1'b0, 1'b0});
    vecs.push_back('{27'd134217727, 21'd2097151, 21'd2097150, 27'd134217727, 1'b1, 1'b0});
    vecs.push_back('{27'd0, 21'd7, 21'd6, 27'd6, 1'b0, 1'b0});
    vecs.push_back('{27'd1000, 21'd1000, 21'd999, 27'd1000999, 1'b0, 1'b0});

    #22 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", bus_if.in_ready, 1);
    check("rst_out_valid", bus_if.out_valid, 0);
    check("rst_numer", bus_if.numer, 0);
    check("rst_overflow", bus_if.overflow, 0);
    check("rst_remain_err", bus_if.remain_err, 0);
`ifdef DIV_RECON_CHECK_EN
    check("rst_fail_sticky", bus_if.fail_sticky, 0);
`endif

    // Latency: 2*3+2 = 8, out_valid 22 clocks after accept.
    send(27'd2, 21'd3, 21'd2, 27'd8, '{27'd8, 1'b0, 1'b0, 1'b1});
    recv("lat");
    check("latency", valid_cyc - accept_cyc, 22);

    // Back-to-back: second accept 24 clocks after the first.
    send(27'd3, 21'd4, 21'd3, 27'd15, '{27'd15, 1'b0, 1'b0, 1'b1});
    acc0 = accept_cyc;
    recv("b2b_a");
    send(27'd5, 21'd3, 21'd1, 27'd16, '{27'd16, 1'b0, 1'b0, 1'b1});
    check("b2b_spacing", accept_cyc - acc0, 24);
    recv("b2b_b");

    // Vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      e.numer = vecs[i].numer;
      e.ovf   = vecs[i].ovf;
      e.rerr  = vecs[i].rerr;
      e.match = !vecs[i].ovf && !vecs[i].rerr;
      send(vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].numer, e);
      recv($sformatf("vec%0d", i));
    end

    // Random operands against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      q = WIDTHN'($urandom);
      d = WIDTHD'($urandom);
      r = (i < 6 && d != '0) ? WIDTHD'($urandom_range(0, int'(d) - 1)) : WIDTHD'($urandom);
      e = model(q, d, r);
      send(q, d, r, e.numer, e);
      recv($sformatf("rnd%0d", i));
    end

    // Stall in DONE: 7*11+3 = 80, held for 10 cycles, in_valid pulse ignored.
    send(27'd7, 21'd11, 21'd3, 27'd80, '{27'd80, 1'b0, 1'b0, 1'b1});
    begin
      int n = 0;
      while (!bus_if.out_valid && n < 60) begin
        @(posedge clk); #1; n++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      check("stall_out_valid", bus_if.out_valid, 1);
      check("stall_numer", bus_if.numer, 80);
      check("stall_flags", {bus_if.overflow, bus_if.remain_err}, 0);
      check("stall_in_ready", bus_if.in_ready, 0);
      if (i == 3) begin
        bus_if.in_valid = 1'b1;
        bus_if.quotient = 27'd1;
        bus_if.denom    = 21'd1;
        bus_if.remain   = 21'd0;
      end else begin
        bus_if.in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b0;
    recv("stall");
    repeat (25) @(posedge clk);
    #1;
    check("stall_pulse_ignored", bus_if.out_valid, 0);
    check("stall_idle_in_ready", bus_if.in_ready, 1);

    // Reset at MUL iteration 10 discards the operation.
    send(27'd123, 21'd456, 21'd7, 27'd0, model(27'd123, 21'd456, 21'd7));
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mrst_numer", bus_if.numer, 0);
    check("mrst_out_valid", bus_if.out_valid, 0);
    check("mrst_in_ready", bus_if.in_ready, 1);
    #2 reset = 1'b0;
    sb.delete();
    sticky_exp = 1'b0;
    @(posedge clk); #1;
    check("mrst_in_ready_after", bus_if.in_ready, 1);
    check("mrst_out_valid_after", bus_if.out_valid, 0);
    check("mrst_flags", {bus_if.overflow, bus_if.remain_err}, 0);
`ifdef DIV_RECON_CHECK_EN
    check("mrst_fail_sticky", bus_if.fail_sticky, 0);
`endif

    // 10/5 with a wrong expectation of 11, then a passing op.
    send(27'd2, 21'd5, 21'd0, 27'd11, '{27'd10, 1'b0, 1'b0, 1'b0});
    recv("post_rst_a");
    send(27'd2, 21'd3, 21'd2, 27'd8, '{27'd8, 1'b0, 1'b0, 1'b1});
    recv("post_rst_b");

    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
